// File: rtl/drum_pkg.sv
// Shared types and constants for the drum strike detector.
package drum_pkg;

  localparam int VEL_W   = 7;
  localparam int VEL_MAX = 127;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SWING   = 2'd1,
    FIRE    = 2'd2,
    HOLDOFF = 2'd3
  } drum_state_t;

  typedef enum logic [1:0] {
    ZONE_LEFT   = 2'd0,
    ZONE_CENTRE = 2'd1,
    ZONE_RIGHT  = 2'd2
  } drum_zone_t;

endpackage

// File: rtl/drum_zone_vel.sv
// Combinational yaw-to-zone classifier and magnitude-to-velocity scaler.
module drum_zone_vel
  import drum_pkg::*;
#(
  parameter int VEL_SHIFT = 6,
  parameter int ZONE_L    = -3000,
  parameter int ZONE_R    = 3000
) (
  input  logic signed [15:0]      yaw,
  input  logic        [16:0]      mag,
  output drum_zone_t              zone,
  output logic        [VEL_W-1:0] velocity
);

  logic [16:0] shifted;

  always_comb begin
    zone = ZONE_CENTRE;
    if (int'(yaw) < ZONE_L) begin
      zone = ZONE_LEFT;
    end else if (int'(yaw) > ZONE_R) begin
      zone = ZONE_RIGHT;
    end
  end

  // Velocity is never reported as zero: a detected strike always sounds.
  always_comb begin
    shifted  = mag >> VEL_SHIFT;
    velocity = shifted[VEL_W-1:0];
    if (shifted > 17'(VEL_MAX)) begin
      velocity = VEL_W'(VEL_MAX);
    end else if (shifted == 17'd0) begin
      velocity = VEL_W'(1);
    end
  end

endmodule

// File: rtl/drum_strike_detector.sv
// Gyro-pitch drum strike detector with hysteresis, swing timeout and refractory holdoff.
// Define STRIKE_PEAK_VEL_EN to derive velocity from the swing peak instead of the onset sample.
module drum_strike_detector
  import drum_pkg::*;
#(
  parameter int THRESH_ON         = 2000,
  parameter int THRESH_OFF        = 500,
  parameter int REFRACT_SAMPLES   = 10,
  parameter int MAX_SWING_SAMPLES = 50,
  parameter int VEL_SHIFT         = 6,
  parameter int ZONE_L            = -3000,
  parameter int ZONE_R            = 3000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sensor_ok,
  input  logic               gyro_valid,
  input  logic signed [15:0] gyro_y,
  input  logic signed [15:0] yaw,
  output logic               strike_valid,
  output logic [1:0]         strike_zone,
  output logic [VEL_W-1:0]   strike_velocity,
  output logic [15:0]        strike_count,
  output logic               busy
);

  drum_state_t state_reg, state_next;

  logic               valid_d_reg;
  logic               samp_stb_reg;
  logic signed [15:0] samp_gyro_reg;
  logic signed [15:0] samp_yaw_reg;
  logic signed [16:0] gyro_ext;
  logic        [16:0] mag;
  logic               gyro_on;
  logic               gyro_off;

  logic [15:0]        swing_cnt_reg, swing_cnt_next;
  logic [15:0]        refr_cnt_reg, refr_cnt_next;
  logic               load_onset;
  logic signed [15:0] yaw_cap_reg;
  logic        [16:0] mag_sel;

  logic               strike_valid_reg;
  drum_zone_t         strike_zone_reg;
  logic [VEL_W-1:0]   strike_velocity_reg;
  logic [15:0]        strike_count_reg;
  drum_zone_t         zone_w;
  logic [VEL_W-1:0]   vel_w;
  logic               fire_next;

  // Rising-edge detect: the sample is registered together with the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_d_reg   <= 1'b0;
      samp_stb_reg  <= 1'b0;
      samp_gyro_reg <= '0;
      samp_yaw_reg  <= '0;
    end else begin
      valid_d_reg  <= gyro_valid;
      samp_stb_reg <= gyro_valid & ~valid_d_reg;
      if (gyro_valid & ~valid_d_reg) begin
        samp_gyro_reg <= gyro_y;
        samp_yaw_reg  <= yaw;
      end
    end
  end

  // 17-bit magnitude so that -32768 maps to +32768.
  assign gyro_ext = {samp_gyro_reg[15], samp_gyro_reg};
  assign mag      = samp_gyro_reg[15] ? 17'(-gyro_ext) : 17'(gyro_ext);
  assign gyro_on  = int'(samp_gyro_reg) < -THRESH_ON;
  assign gyro_off = int'(samp_gyro_reg) >= -THRESH_OFF;

  always_comb begin
    state_next     = state_reg;
    swing_cnt_next = swing_cnt_reg;
    refr_cnt_next  = refr_cnt_reg;
    load_onset     = 1'b0;
    if (!sensor_ok) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (samp_stb_reg && gyro_on) begin
            state_next     = SWING;
            swing_cnt_next = '0;
            load_onset     = 1'b1;
          end
        end
        SWING: begin
          if (samp_stb_reg) begin
            swing_cnt_next = swing_cnt_reg + 16'd1;
            if (gyro_off) begin
              state_next = FIRE;
            end else if (swing_cnt_next == 16'(MAX_SWING_SAMPLES)) begin
              state_next = IDLE;
            end
          end
        end
        FIRE: begin
          state_next    = HOLDOFF;
          refr_cnt_next = '0;
        end
        HOLDOFF: begin
          if (samp_stb_reg) begin
            refr_cnt_next = refr_cnt_reg + 16'd1;
            if (refr_cnt_next == 16'(REFRACT_SAMPLES)) begin
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign fire_next = (state_next == FIRE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      swing_cnt_reg <= '0;
      refr_cnt_reg  <= '0;
      yaw_cap_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      swing_cnt_reg <= swing_cnt_next;
      refr_cnt_reg  <= refr_cnt_next;
      if (load_onset) begin
        yaw_cap_reg <= samp_yaw_reg;
      end
    end
  end

`ifdef STRIKE_PEAK_VEL_EN
  logic [16:0] peak_reg, peak_next;

  // Include the current sample so the release sample can still raise the peak.
  always_comb begin
    peak_next = peak_reg;
    if (state_reg == SWING && samp_stb_reg && mag > peak_reg) begin
      peak_next = mag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_reg <= '0;
    end else if (load_onset) begin
      peak_reg <= mag;
    end else begin
      peak_reg <= peak_next;
    end
  end

  assign mag_sel = peak_next;
`else
  logic [16:0] onset_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      onset_reg <= '0;
    end else if (load_onset) begin
      onset_reg <= mag;
    end
  end

  assign mag_sel = onset_reg;
`endif

  drum_zone_vel #(
    .VEL_SHIFT (VEL_SHIFT),
    .ZONE_L    (ZONE_L),
    .ZONE_R    (ZONE_R)
  ) u_zone_vel (
    .yaw      (yaw_cap_reg),
    .mag      (mag_sel),
    .zone     (zone_w),
    .velocity (vel_w)
  );

  // Strike outputs are loaded on entry to FIRE so they align with the pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strike_valid_reg    <= 1'b0;
      strike_zone_reg     <= ZONE_LEFT;
      strike_velocity_reg <= '0;
      strike_count_reg    <= '0;
    end else begin
      strike_valid_reg <= fire_next;
      if (fire_next) begin
        strike_zone_reg     <= zone_w;
        strike_velocity_reg <= vel_w;
        strike_count_reg    <= strike_count_reg + 16'd1;
      end
    end
  end

  assign strike_valid    = strike_valid_reg;
  assign strike_zone     = strike_zone_reg;
  assign strike_velocity = strike_velocity_reg;
  assign strike_count    = strike_count_reg;
  assign busy            = (state_reg != IDLE);

endmodule

// File: tb/tb_drum_strike_detector.sv
// Directed scoreboard bench for drum_strike_detector; honours STRIKE_PEAK_VEL_EN for velocity expectations.
module tb_drum_strike_detector;

  logic               clk;
  logic               rst;
  logic               sensor_ok;
  logic               gyro_valid;
  logic signed [15:0] gyro_y;
  logic signed [15:0] yaw;
  logic               strike_valid;
  logic [1:0]         strike_zone;
  logic [6:0]         strike_velocity;
  logic [15:0]        strike_count;
  logic               busy;

  typedef struct {
    int zone;
    int vel;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_rise_cyc = 0;
  int   exp_count = 0;

  drum_strike_detector dut (
    .clk             (clk),
    .rst             (rst),
    .sensor_ok       (sensor_ok),
    .gyro_valid      (gyro_valid),
    .gyro_y          (gyro_y),
    .yaw             (yaw),
    .strike_valid    (strike_valid),
    .strike_zone     (strike_zone),
    .strike_velocity (strike_velocity),
    .strike_count    (strike_count),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference velocity: magnitude >> 6, clamped to 1..127.
  function automatic int vel_of(input int m);
    int v;
    v = m >> 6;
    if (v > 127) v = 127;
    if (v < 1) v = 1;
    return v;
  endfunction

  function automatic int pick_vel(input int onset, input int peak);
`ifdef STRIKE_PEAK_VEL_EN
    return vel_of(peak);
`else
    return vel_of(onset);
`endif
  endfunction

  task automatic push_exp(input int z, input int v);
    exp_t e;
    exp_count = (exp_count + 1) & 32'hFFFF;
    e.zone = z;
    e.vel  = v;
    e.cnt  = exp_count;
    sb.push_back(e);
  endtask

  task automatic send_sample(input int gy, input int yw);
    @(negedge clk);
    gyro_y        = 16'(gy);
    yaw           = 16'(yw);
    gyro_valid    = 1'b1;
    last_rise_cyc = cyc;
    @(negedge clk);
    gyro_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic holdoff_clear();
    repeat (10) send_sample(0, 0);
  endtask

  // Monitor: every strike pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && strike_valid === 1'b1) begin
      check("strike_expected", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("strike_zone", strike_zone, e.zone);
        check("strike_velocity", strike_velocity, e.vel);
        check("strike_count", strike_count, e.cnt);
        check("strike_latency", cyc - last_rise_cyc, 2);
        $display("strike zone=%0d vel=%0d count=%0d", strike_zone, strike_velocity, strike_count);
      end
    end
  end

  initial begin
    int yaws[3];
    yaws[0] = -3001;
    yaws[1] = 3000;
    yaws[2] = 3001;

    rst        = 1'b1;
    sensor_ok  = 1'b1;
    gyro_valid = 1'b0;
    gyro_y     = '0;
    yaw        = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", strike_valid, 0);
    check("rst_zone", strike_zone, 0);
    check("rst_vel", strike_velocity, 0);
    check("rst_count", strike_count, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // Onset vs peak velocity
    send_sample(0, 0);
    send_sample(-1000, 0);
    check("idle_below_thresh", busy, 0);
    send_sample(-2500, 0);
    check("swing_busy", busy, 1);
    send_sample(-6400, 0);
    send_sample(-3000, 0);
    push_exp(1, pick_vel(2500, 6400));
    send_sample(-200, 0);
    check("count_after_first", strike_count, 1);
    holdoff_clear();
    check("idle_after_holdoff", busy, 0);

    // Zone boundaries and saturation
    for (int i = 0; i < 3; i++) begin
      send_sample(-2500, yaws[i]);
      send_sample(-32768, yaws[i]);
      push_exp(i, pick_vel(2500, 32768));
      send_sample(0, yaws[i]);
      holdoff_clear();
    end
    check("zone_hold", strike_zone, 2);
    check("vel_hold", strike_velocity, pick_vel(2500, 32768));

    // Refractory: samples inside holdoff never start a swing
    send_sample(-5000, 0);
    push_exp(1, pick_vel(5000, 5000));
    send_sample(0, 0);
    for (int i = 0; i < 10; i++) begin
      send_sample((i % 2 == 0) ? -5000 : 0, 0);
    end
    check("holdoff_done_idle", busy, 0);
    send_sample(-5000, 0);
    check("post_holdoff_swing", busy, 1);
    push_exp(1, pick_vel(5000, 5000));
    send_sample(0, 0);
    check("count_refractory", strike_count, 6);
    holdoff_clear();

    // Swing timeout
    repeat (50) send_sample(-3000, 0);
    check("swing_50_busy", busy, 1);
    send_sample(-3000, 0);
    check("swing_timeout_idle", busy, 0);
    check("timeout_count_hold", strike_count, exp_count);

    // sensor_ok drop mid-swing
    send_sample(-5000, 0);
    check("swing_before_drop", busy, 1);
    @(negedge clk);
    sensor_ok = 1'b0;
    @(negedge clk);
    check("sensor_drop_idle", busy, 0);
    sensor_ok = 1'b1;
    send_sample(0, 0);
    check("sensor_drop_no_strike", strike_count, exp_count);

    // Level-held valid counts once
    @(negedge clk);
    gyro_y     = -16'sd5000;
    yaw        = '0;
    gyro_valid = 1'b1;
    repeat (20) @(negedge clk);
    gyro_valid = 1'b0;
    @(negedge clk);
    check("held_valid_swing", busy, 1);
    repeat (49) send_sample(-3000, 0);
    check("held_valid_no_timeout", busy, 1);
    push_exp(1, pick_vel(5000, 5000));
    send_sample(0, 0);
    holdoff_clear();

    // Reset mid-swing
    send_sample(-5000, 0);
    check("swing_before_rst", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", strike_valid, 0);
    check("rst_mid_zone", strike_zone, 0);
    check("rst_mid_vel", strike_velocity, 0);
    check("rst_mid_count", strike_count, 0);
    check("rst_mid_busy", busy, 0);
    exp_count = 0;
    @(negedge clk);
    rst = 1'b0;
    send_sample(0, 0);
    check("post_rst_idle", busy, 0);

    // Count wrap
    @(negedge clk);
    force dut.strike_count_reg = 16'hFFFF;
    @(negedge clk);
    release dut.strike_count_reg;
    @(negedge clk);
    check("preload_count", strike_count, 16'hFFFF);
    exp_count = 16'hFFFF;
    send_sample(-2500, 0);
    push_exp(1, pick_vel(2500, 2500));
    send_sample(0, 0);
    check("count_wrap", strike_count, 0);
    holdoff_clear();

    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/drum_strike_detector.md
DRUM_STRIKE_DETECTOR -- requirements
Module: drum_strike_detector

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- THRESH_ON, 2000: strike-onset magnitude on gyro Y, in LSB.
- THRESH_OFF, 500: release magnitude (hysteresis).
- REFRACT_SAMPLES, 10: holdoff length after a strike, in samples.
- MAX_SWING_SAMPLES, 50: abort limit for a swing.
- VEL_SHIFT, 6: right shift applied to the magnitude to form velocity.
- ZONE_L, -3000: yaw boundary between zone 0 and zone 1.
- ZONE_R, 3000: yaw boundary between zone 1 and zone 2.

REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1: system clock; one clock only.
- rst, in, 1: reset; asynchronous, active-high.
- sensor_ok, in, 1: sensor initialized and no error.
- gyro_valid, in, 1: level-valid for the gyro sample.
- gyro_y, in, 16 signed: pitch rate.
- yaw, in, 16 signed: yaw angle, carried in the quat_z field downstream of the sensor SPI slave.
- strike_valid, out, 1: one-cycle strike pulse.
- strike_zone, out, 2: 0 = left, 1 = centre, 2 = right.
- strike_velocity, out, 7: velocity, 1..127.
- strike_count, out, 16: total strikes emitted.
- busy, out, 1: state is not IDLE.

Function
REQ-003 A sample SHALL be accepted only on the cycle after gyro_valid rises (registered edge detect); a level held high SHALL yield one sample.
REQ-004 mag SHALL be |gyro_y| computed in 17 bits, so that -32768 gives 32768 without overflow.
REQ-005 The FSM SHALL have states IDLE, SWING, FIRE and HOLDOFF.
REQ-006 IDLE->SWING SHALL occur on an accepted sample with gyro_y < -THRESH_ON.
- On entry: capture yaw for zone, set peak = mag, clear the swing counter, capture onset mag.
REQ-007 In SWING, per accepted sample:
- peak = max(peak, mag).
- The swing counter increments.
- If gyro_y >= -THRESH_OFF, go to FIRE.
- Else if swing counter = MAX_SWING_SAMPLES, go to IDLE with no strike.
REQ-008 FIRE SHALL last exactly one cycle:
- strike_valid = 1.
- Zone, velocity and count are updated in the same cycle.
- Next state is HOLDOFF with the refractory counter cleared.
REQ-009 Latency: strike_valid SHALL assert 2 clk cycles after the gyro_valid rising edge of the release sample.
REQ-010 HOLDOFF SHALL count accepted samples and return to IDLE after REFRACT_SAMPLES samples. Samples in HOLDOFF SHALL never start a swing.
REQ-011 Zone classification: yaw < ZONE_L gives 0; yaw > ZONE_R gives 2; otherwise 1. The comparisons are signed and boundary values map to 1.
REQ-012 Velocity SHALL be (selected mag >> VEL_SHIFT), saturated to 127 and floored to 1.
REQ-013 strike_count SHALL wrap from 0xFFFF to 0x0000.
REQ-014 When sensor_ok = 0 in any state, the FSM SHALL go to IDLE on the next cycle with no strike, and strike_count SHALL hold.
REQ-015 strike_zone and strike_velocity SHALL hold their last values between strikes.

Reset
REQ-016 On rst, the block SHALL go immediately to IDLE.
- strike_valid = 0, strike_zone = 0, strike_velocity = 0, strike_count = 0, busy = 0.
- All counters, peak and the edge-detect register are cleared.
REQ-017 Reset asserted mid-SWING or mid-HOLDOFF SHALL abort without a strike pulse. The first sample after release is evaluated from IDLE.

Configuration
REQ-018 Macro STRIKE_PEAK_VEL_EN:
- Defined: velocity uses the peak mag tracked over the SWING.
- Undefined: velocity uses the onset mag captured at IDLE->SWING, and the peak register is not built.

Structure
REQ-019 Package drum_pkg SHALL hold:
- the FSM state enum;
- the zone typedef (2 bits, ZONE_LEFT/CENTRE/RIGHT);
- VEL_W = 7 and VEL_MAX = 127.
REQ-020 Zone comparison and velocity shift/saturation SHALL live in one combinational sub-module, drum_zone_vel.

Verification
REQ-021 Peak velocity: yaw = 0; gyro_y samples 0, -1000, -2500, -6400, -3000, -200.
- One strike_valid, zone = 1.
- Velocity = 100 with STRIKE_PEAK_VEL_EN defined; 39 without it.
- strike_count = 1.
REQ-022 Zone edges and saturation: yaw = -3001 then 3000 then 3001, each with swing -2500/-32768/0.
- Zones 0, 1, 2.
- Velocity 127 each time with the macro defined.
REQ-023 Refractory: strike, then -5000, 0 repeated during the next 10 samples.
- No second strike.
- The 11th sample of -5000 starts a SWING, and its release yields strike_count = 2.
REQ-024 Timeout and abort:
- 51 consecutive -3000 samples: return to IDLE with no strike.
- sensor_ok dropped mid-SWING: busy = 0 next cycle, no strike.
REQ-025 Reset and wrap:
- rst pulsed during SWING: outputs zero and no pulse.
- Preload strike_count to 0xFFFF via 65535 forced strikes (or a force): the next strike gives 0x0000.
REQ-026 Held valid: gyro_valid held high for 20 cycles with gyro_y = -5000 SHALL count as exactly one sample.
